// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over
// GATE_CYCLES clocks and latches a saturated 20-bit result per window.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned MAX_COUNT   = 99_999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sig_in,
  output logic [19:0] freq_out,
  output logic        overflow,
  output logic        valid,
  output logic        gate_active
);

  localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [20:0]   MAXV      = 21'(MAX_COUNT);
  localparam logic [20:0]   SATV      = 21'(MAX_COUNT + 1);

  logic          s1_q, s2_q, s3_q;
  logic [GW-1:0] gate_q, gate_d;
  logic [20:0]   edge_q, edge_d;
  logic [19:0]   freq_q, freq_d;
  logic          ovf_q, ovf_d;
  logic          valid_q, valid_d;
  logic          e;
  logic          terminal;
  logic [21:0]   total;

  assign e        = s2_q & ~s3_q;
  assign terminal = (gate_q == GATE_LAST);
  assign total    = {1'b0, edge_q} + {21'b0, e};

  always_comb begin
    gate_d  = terminal ? '0 : gate_q + GW'(1);
    edge_d  = edge_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (terminal) begin
      // an edge seen on the terminal cycle belongs to the closing window
      if (total > {1'b0, MAXV}) begin
        freq_d = MAXV[19:0];
        ovf_d  = 1'b1;
      end else begin
        freq_d = total[19:0];
        ovf_d  = 1'b0;
      end
      valid_d = 1'b1;
      edge_d  = '0;
    end else if (edge_q != SATV) begin
      edge_d = total[20:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      gate_q  <= '0;
      edge_q  <= '0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s1_q    <= sig_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      gate_q  <= gate_d;
      edge_q  <= edge_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign freq_out    = freq_q;
  assign overflow    = ovf_q;
  assign valid       = valid_q;
  // reserved for a future hold/arm control; follows reset directly
  assign gate_active = rst_n;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with GATE_CYCLES=100, MAX_COUNT=20.
module tb_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_in = 1'b0;
  logic [19:0] freq_out;
  logic        overflow;
  logic        valid;
  logic        gate_active;

  freq_meter #(.GATE_CYCLES(100), .MAX_COUNT(20)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
    .freq_out(freq_out), .overflow(overflow), .valid(valid),
    .gate_active(gate_active)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;
  int mode    = 0;   // 0 constant, 1 square wave, 2 single pulse
  int cval    = 0;
  int per     = 10;
  int hi      = 5;
  int off     = 0;
  int pe      = 0;
  logic [19:0] hold_f  = '0;
  logic        hold_ov = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input level applied before posedge number n (1-based since reset release).
  function automatic logic lvl(input int n);
    case (mode)
      1:       return ((n + off) % per) < hi;
      2:       return (n >= pe) && (n < pe + 5);
      default: return cval != 0;
    endcase
  endfunction

  task automatic tick();
    sig_in = lvl(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
    chk("valid_timing", {31'b0, valid}, {31'b0, (cyc % 100) == 0});
    chk("gate_active", {31'b0, gate_active}, 32'd1);
    if ((cyc % 100) != 0) begin
      chk("freq_hold", {12'b0, freq_out}, {12'b0, hold_f});
      chk("ovf_hold", {31'b0, overflow}, {31'b0, hold_ov});
    end
  endtask

  task automatic window(input string tag, input int ef, input int eov);
    repeat (100) tick();
    chk({tag, "_freq"}, {12'b0, freq_out}, ef);
    chk({tag, "_ovf"}, {31'b0, overflow}, eov);
    hold_f  = 20'(ef);
    hold_ov = eov[0];
  endtask

  task automatic do_reset(input logic level);
    rst_n  = 1'b0;
    sig_in = level;
    #1;
    chk("rst_freq", {12'b0, freq_out}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_gate_active", {31'b0, gate_active}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    cyc     = 0;
    hold_f  = '0;
    hold_ov = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;

    // 1: idle input
    mode = 0; cval = 0;
    do_reset(1'b0);
    window("idle_w1", 0, 0);
    window("idle_w2", 0, 0);
    window("idle_w3", 0, 0);

    // 2: period-10 wave, rises away from the window boundary
    mode = 1; per = 10; hi = 5; off = 5;
    do_reset(1'b0);
    window("p10_w1", 10, 0);
    window("p10_w2", 10, 0);
    window("p10_w3", 10, 0);

    // exactly MAX_COUNT edges: no overflow
    mode = 1; per = 5; hi = 2; off = 4;
    do_reset(1'b0);
    window("p5_w1", 20, 0);
    window("p5_w2", 20, 0);

    // 25 edges: saturate
    mode = 1; per = 4; hi = 2; off = 3;
    do_reset(1'b0);
    window("p4_w1", 20, 1);

    // 3: period-2 wave then idle; last rise lands in the following window
    mode = 1; per = 2; hi = 1; off = 0;
    do_reset(1'b0);
    window("p2_w1", 20, 1);
    window("p2_w2", 20, 1);
    mode = 0; cval = 0;
    window("p2_tail", 1, 0);
    window("p2_idle", 0, 0);

    // 4: single edge counted on the terminal cycle
    mode = 2; pe = 98;
    do_reset(1'b0);
    window("term_w1", 1, 0);
    window("term_w2", 0, 0);

    // one cycle later: falls into the next window
    mode = 2; pe = 99;
    do_reset(1'b0);
    window("late_w1", 0, 0);
    window("late_w2", 1, 0);

    // 5: asynchronous reset mid-window
    mode = 1; per = 10; hi = 5; off = 5;
    do_reset(1'b0);
    window("mid_w1", 10, 0);
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    chk("async_freq", {12'b0, freq_out}, 32'd0);
    chk("async_ovf", {31'b0, overflow}, 32'd0);
    chk("async_valid", {31'b0, valid}, 32'd0);
    do_reset(1'b0);
    window("mid_after", 10, 0);

    // 6: input high across reset release
    mode = 0; cval = 1;
    do_reset(1'b1);
    window("high_w1", 1, 0);
    window("high_w2", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
